// File: rtl/fifo_ram.sv
// Register-array storage for strobe_fifo. It has one synchronous write port
// and one asynchronous read port. The array has no reset; its contents only
// matter once the control logic marks them valid.
module fifo_ram #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [WIDTH-1:0] mem [DEPTH];

  // write port: one word per cycle, no reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // read port is combinational so the head falls through in the cycle after a push
  assign rdata = mem[raddr];

endmodule

// File: rtl/strobe_fifo.sv
// Destination-side queue for synchronised strobe pulses. The head entry is
// presented first-word-fall-through on a valid/ready interface. The block also
// provides an occupancy count, a full flag and a sticky overflow flag.
module strobe_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  strobe_in,
  input  logic [WIDTH-1:0]      data_in,
  output logic [WIDTH-1:0]      data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  overflow,
  input  logic                  clear_overflow
);

  localparam int                CW        = DEPTH_LOG2 + 1;
  localparam int                DEPTH     = 2 ** DEPTH_LOG2;
  localparam logic [CW-1:0]     DEPTH_CNT = CW'(DEPTH);

  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [WIDTH-1:0]      head;
  logic                  push;
  logic                  pop;

  // full is judged before any same-cycle pop, so a strobe into a full queue
  // is always dropped, even when the head leaves in that cycle
  assign full       = (count == DEPTH_CNT);
  assign data_valid = (count != '0);
  assign push       = strobe_in & ~full;
  assign pop        = data_valid & data_ready;

  fifo_ram #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .we    (push & reset_n),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // stale memory never leaks out while empty
  assign data_out = data_valid ? head : '0;

  // pointers wrap naturally at DEPTH; reset discards any queued words
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // occupancy: a simultaneous push and pop leave it unchanged
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (push && !pop) begin
      count <= count + 1'b1;
    end else if (pop && !push) begin
      count <= count - 1'b1;
    end
  end

  // sticky overflow: if a set and a clear occur in the same cycle, the set wins
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (strobe_in && full) begin
      overflow <= 1'b1;
    end else if (clear_overflow) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_strobe_fifo.sv
// Self-checking bench for strobe_fifo. A queue-based model tracks the
// expected contents and flags. Every output is compared with the model each
// cycle, on the falling edge.
module tb_strobe_fifo;

  localparam int WIDTH      = 8;
  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 16;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                strobe_in;
  logic [WIDTH-1:0]    data_in;
  logic [WIDTH-1:0]    data_out;
  logic                data_valid;
  logic                data_ready;
  logic [DEPTH_LOG2:0] count;
  logic                full;
  logic                overflow;
  logic                clear_overflow;

  int n_chk  = 0;
  int n_pass = 0;

  // reference state
  logic [WIDTH-1:0] q[$];
  bit               m_ovf;

  strobe_fifo #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .strobe_in      (strobe_in),
    .data_in        (data_in),
    .data_out       (data_out),
    .data_valid     (data_valid),
    .data_ready     (data_ready),
    .count          (count),
    .full           (full),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // compare all outputs with the model, then advance one edge and update the model
  task automatic cyc();
    bit was_full;
    @(negedge clk);
    chk("count", 32'(count),      32'(q.size()));
    chk("valid", 32'(data_valid), 32'(q.size() > 0));
    chk("dout",  32'(data_out),   q.size() > 0 ? 32'(q[0]) : 32'h0);
    chk("full",  32'(full),       32'(q.size() == DEPTH));
    chk("ovf",   32'(overflow),   32'(m_ovf));
    @(posedge clk);
    if (!reset_n) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      was_full = (q.size() == DEPTH);
      if (data_ready && q.size() > 0) void'(q.pop_front());
      if (strobe_in && !was_full) q.push_back(data_in);
      if (strobe_in && was_full) m_ovf = 1'b1;
      else if (clear_overflow)   m_ovf = 1'b0;
    end
    #1;
  endtask

  task automatic idle();
    strobe_in = 0; data_ready = 0; clear_overflow = 0; reset_n = 1;
  endtask

  task automatic push(input logic [WIDTH-1:0] d);
    strobe_in = 1; data_in = d;
    cyc();
    strobe_in = 0;
  endtask

  initial begin
    q.delete();
    m_ovf = 0;
    data_in = '0;
    idle();

    // reset for two cycles, then stay idle
    reset_n = 0;
    cyc(); cyc();
    reset_n = 1;
    for (int i = 0; i < 10; i++) cyc();

    // single word, then pop it
    push(8'hA5);
    cyc();
    chk("single_head", 32'(data_out), 32'hA5);
    data_ready = 1; cyc(); data_ready = 0;
    cyc();

    // fill the queue, overflow with 0xFF, then drain in order
    for (int i = 0; i < 16; i++) push(8'(i));
    chk("fill_full", 32'(full), 32'h1);
    push(8'hFF);
    for (int i = 0; i < 16; i++) begin
      chk("drain_order", 32'(data_out), 32'(i));
      data_ready = 1; cyc();
    end
    data_ready = 0;
    cyc();
    clear_overflow = 1; cyc(); clear_overflow = 0;
    cyc();

    // wrap-around: pop every cycle while pushing every cycle
    data_ready = 1;
    for (int i = 0; i < 40; i++) push(8'(8'h10 + i));
    cyc();
    data_ready = 0;
    cyc();

    // push and pop together while full: the push is dropped and overflow is set
    for (int i = 0; i < 16; i++) push(8'(8'h80 + i));
    strobe_in = 1; data_in = 8'hEE; data_ready = 1;
    cyc();
    strobe_in = 0; data_ready = 0;
    chk("fp_count", 32'(count), 32'd15);
    push(8'h90);
    clear_overflow = 1; strobe_in = 1; data_in = 8'hEF;
    cyc();
    clear_overflow = 0; strobe_in = 0;
    chk("set_beats_clr", 32'(overflow), 32'h1);
    data_ready = 1;
    for (int i = 0; i < 17; i++) begin
      chk("no_ee", 32'(data_out == 8'hEE), 32'h0);
      cyc();
    end
    data_ready = 0; clear_overflow = 1; cyc(); clear_overflow = 0;

    // reset while work is in flight
    for (int i = 0; i < 5; i++) push(8'(8'h30 + i));
    reset_n = 0; strobe_in = 1; data_in = 8'h77;
    cyc();
    reset_n = 1; strobe_in = 0;
    chk("rst_count", 32'(count), 32'h0);
    push(8'h42);
    chk("post_rst_head", 32'(data_out), 32'h42);
    data_ready = 1; cyc(); data_ready = 0;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      strobe_in      = ($urandom_range(0, 99) < 60);
      data_in        = 8'($urandom);
      data_ready     = ($urandom_range(0, 99) < 45);
      clear_overflow = ($urandom_range(0, 99) < 5);
      reset_n        = ($urandom_range(0, 499) != 0);
      cyc();
    end
    idle();
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
